// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// Op encodings, default latencies and the control state type.
package mdu_pkg;

  localparam int MDU_WIDTH       = 32;
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;

  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;
  localparam logic [2:0] MDU_RSVD  = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mdu_state_e;

  function automatic int mdu_max(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned divider.
// Flags divide-by-zero and the single signed overflow case.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_dz,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_ua;
  logic [WIDTH-1:0] w_ub;
  logic [WIDTH-1:0] w_ub_safe;
  logic [WIDTH-1:0] w_uq;
  logic [WIDTH-1:0] w_ur;

  assign w_neg_a = i_signed & i_a[WIDTH-1];
  assign w_neg_b = i_signed & i_b[WIDTH-1];
  assign o_dz    = (i_b == '0);
  assign o_ovf   = i_signed & (i_a == MIN_NEG) & (i_b == '1);

  // Divide magnitudes, then restore signs (quotient toward zero,
  // remainder follows the dividend). Zero divisor is steered to 1
  // so the datapath stays defined; the caller discards the result.
  always_comb begin
    w_ua      = w_neg_a ? (~i_a + ONE) : i_a;
    w_ub      = w_neg_b ? (~i_b + ONE) : i_b;
    w_ub_safe = o_dz ? ONE : w_ub;
    w_uq      = w_ua / w_ub_safe;
    w_ur      = w_ua % w_ub_safe;
    o_quot    = (w_neg_a ^ w_neg_b) ? (~w_uq + ONE) : w_uq;
    o_rem     = w_neg_a ? (~w_ur + ONE) : w_ur;
    if (o_ovf) begin
      o_quot = MIN_NEG;
      o_rem  = '0;
    end
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Result is computed at accept, held in a shadow, committed after N cycles.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXN = mdu_max(MULT_CYCLES, DIV_CYCLES);
  localparam int CW   = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  mdu_state_e       r_state;
  mdu_state_e       w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shi;
  logic [WIDTH-1:0] r_slo;
  logic             r_skip;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_acc;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_long;
  logic             w_commit;
  logic [2*WIDTH-1:0] w_sa;
  logic [2*WIDTH-1:0] w_sb;
  logic [2*WIDTH-1:0] w_ua;
  logic [2*WIDTH-1:0] w_ub;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic             w_dz;
  logic             w_ovf;
  logic             w_div_sgn;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_res_skip;

  assign busy = (r_state == S_BUSY);
  assign hi   = r_hi;
  assign lo   = r_lo;

  assign w_acc    = start & ~busy;
  assign w_is_mul = (op == MDU_MULT) | (op == MDU_MULTU);
  assign w_is_div = (op == MDU_DIV) | (op == MDU_DIVU);
  assign w_long   = w_acc & (w_is_mul | w_is_div);

  // Low 2W bits of the product of sign-extended operands are the
  // signed product; zero-extended gives the unsigned one.
  assign w_sa     = {{WIDTH{a[WIDTH-1]}}, a};
  assign w_sb     = {{WIDTH{b[WIDTH-1]}}, b};
  assign w_ua     = {{WIDTH{1'b0}}, a};
  assign w_ub     = {{WIDTH{1'b0}}, b};
  assign w_prod_s = w_sa * w_sb;
  assign w_prod_u = w_ua * w_ub;

  assign w_div_sgn = (op == MDU_DIV);

  mdu_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .i_a      (a),
    .i_b      (b),
    .i_signed (w_div_sgn),
    .o_quot   (w_quot),
    .o_rem    (w_rem),
    .o_dz     (w_dz),
    .o_ovf    (w_ovf)
  );

  // Select the result that will be parked in the shadow at accept.
  always_comb begin
    w_res_hi   = '0;
    w_res_lo   = '0;
    w_res_skip = 1'b0;
    unique case (op)
      MDU_MULT: begin
        w_res_hi = w_prod_s[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_s[WIDTH-1:0];
      end
      MDU_MULTU: begin
        w_res_hi = w_prod_u[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod_u[WIDTH-1:0];
      end
      MDU_DIV, MDU_DIVU: begin
        w_res_hi   = w_rem;
        w_res_lo   = w_quot;
        w_res_skip = w_dz;
      end
      default: ;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and commit strobe: commit on the edge the counter is spent.
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_long) w_next = S_BUSY;
      end
      S_BUSY: begin
        if (r_cnt == '0) begin
          w_next   = S_IDLE;
          w_commit = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Down-counter and shadow result, loaded on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_shi  <= '0;
      r_slo  <= '0;
      r_skip <= 1'b0;
    end else if (w_long) begin
      r_cnt  <= w_is_mul ? MUL_LOAD : DIV_LOAD;
      r_shi  <= w_res_hi;
      r_slo  <= w_res_lo;
      r_skip <= w_res_skip;
    end else if (busy && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Architectural HI/LO: written only by commit or MTHI/MTLO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (!r_skip) begin
        r_hi <= r_shi;
        r_lo <= r_slo;
      end
    end else if (w_acc && (op == MDU_MTHI)) begin
      r_hi <= a;
    end else if (w_acc && (op == MDU_MTLO)) begin
      r_lo <= a;
    end
  end

endmodule
